// File: rtl/detector_arbiter_pkg.sv
// Shared encodings and default widths for the detector arbiter slice.
package detector_arbiter_pkg;

    localparam int unsigned WORD_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        Z0 = 2'd0,
        Z1 = 2'd1,
        Z2 = 2'd2
    } det_state_e;

endpackage

// File: rtl/detector_arbiter_if.sv
// Requester/result bus between the two requesters and the arbiter.
interface detector_arbiter_if
    import detector_arbiter_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);
    logic              req_a;
    logic [WORD_W-1:0] word_a;
    logic              req_b;
    logic [WORD_W-1:0] word_b;
    logic [1:0]        grant;
    logic              busy;
    logic              ser_bit;
    logic              done;
    logic              done_id;
    logic [CNT_W-1:0]  match_count;

    modport master (
        output req_a, word_a, req_b, word_b,
        input  grant, busy, ser_bit, done, done_id, match_count
    );

    modport slave (
        input  req_a, word_a, req_b, word_b,
        output grant, busy, ser_bit, done, done_id, match_count
    );
endinterface

// File: rtl/zero_pair_detector.sv
// Moore detector: out is high once the last two consumed bits were both 0.
module zero_pair_detector
    import detector_arbiter_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic in,
    output logic out
);
    det_state_e state_q;
    det_state_e state_d;
    det_state_e base;

    // Next state; clear restarts from Z0 while still consuming this cycle's bit.
    always_comb begin
        base    = clear ? Z0 : state_q;
        state_d = Z0;
        if (!in) begin
            case (base)
                Z0:      state_d = Z1;
                Z1:      state_d = Z2;
                default: state_d = Z2;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= Z0;
        else         state_q <= state_d;
    end

    assign out = (state_q == Z2);
endmodule

// File: rtl/detector_arbiter.sv
// Round-robin arbiter serialising one requester's word into a shared "00" detector.
module detector_arbiter
    import detector_arbiter_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
)(
    input  logic               clk,
    input  logic               resetn,
    detector_arbiter_if.slave  bus
);
    localparam int unsigned      BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [1:0]        grant_c;
    logic              pick_b;
    logic              load;
    logic              last_bit;
    logic              det_in;
    logic              det_out;
    logic [WORD_W-1:0] shreg_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  acc_q;
    logic [CNT_W-1:0]  match_count_q;
    logic              ptr_b_q;
    logic              owner_q;
    logic              done_id_q;

    // Round-robin pick: B wins when alone or when it holds the pointer.
    always_comb begin
        pick_b = bus.req_b && (!bus.req_a || ptr_b_q);
    end

    assign last_bit = (bit_cnt_q == LAST_BIT);
    assign load     = (grant_c != 2'b00);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state and grant pulse; grant is suppressed while reset is held.
    always_comb begin
        state_d = state_q;
        grant_c = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (resetn && (bus.req_a || bus.req_b)) begin
                    grant_c = pick_b ? 2'b10 : 2'b01;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT:  if (last_bit) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Detector is fed one bit ahead of ser_bit so its Moore output for the
    // final bit is already visible during the last SHIFT cycle.
    always_comb begin
        if (state_q == ST_IDLE) det_in = pick_b ? bus.word_b[WORD_W-1] : bus.word_a[WORD_W-1];
        else                    det_in = shreg_q[WORD_W-2];
    end

    zero_pair_detector u_det (
        .clk    (clk),
        .resetn (resetn),
        .clear  (load),
        .in     (det_in),
        .out    (det_out)
    );

    // Job datapath: word load, shifting, detection accumulation and result capture.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            acc_q         <= '0;
            match_count_q <= '0;
            ptr_b_q       <= 1'b0;
            owner_q       <= 1'b0;
            done_id_q     <= 1'b0;
        end else if (load) begin
            shreg_q   <= pick_b ? bus.word_b : bus.word_a;
            bit_cnt_q <= '0;
            acc_q     <= '0;
            ptr_b_q   <= !pick_b;
            owner_q   <= pick_b;
        end else if (state_q == ST_SHIFT) begin
            shreg_q   <= shreg_q << 1;
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            acc_q     <= acc_q + CNT_W'(det_out);
            if (last_bit) begin
                match_count_q <= acc_q + CNT_W'(det_out);
                done_id_q     <= owner_q;
            end
        end
    end

    assign bus.grant       = grant_c;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.ser_bit     = (state_q == ST_SHIFT) ? shreg_q[WORD_W-1] : 1'b0;
    assign bus.done        = (state_q == ST_REPORT);
    assign bus.done_id     = done_id_q;
    assign bus.match_count = match_count_q;
endmodule

// File: tb/tb_detector_arbiter.sv
// Directed self-checking bench for detector_arbiter.
module tb_detector_arbiter;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    detector_arbiter_if bus_if ();

    detector_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; the bench always sits at a falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus_if.req_a = 1'b1; bus_if.word_a = 8'hAA;
        bus_if.req_b = 1'b1; bus_if.word_b = 8'h55;
        tick(); tick();
        #1;
        n_checks++; if (bus_if.grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got=%b exp=00", bus_if.grant); end
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
        n_checks++; if (bus_if.ser_bit !== 1'b0) begin n_fail++; $display("FAIL reset_ser got=%b exp=0", bus_if.ser_bit); end
        n_checks++; if (bus_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus_if.done); end
        n_checks++; if (bus_if.done_id !== 1'b0) begin n_fail++; $display("FAIL reset_done_id got=%b exp=0", bus_if.done_id); end
        n_checks++; if (bus_if.match_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus_if.match_count); end
        bus_if.req_a = 1'b0; bus_if.req_b = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        n_checks++; if (bus_if.grant !== 2'b00 || bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL idle_quiet grant=%b busy=%b exp 00/0", bus_if.grant, bus_if.busy); end
        tick();
    endtask

    task automatic test_single_a_zero();
        logic [7:0] w;
        w = 8'h00;
        bus_if.req_a = 1'b1; bus_if.word_a = w;
        #1;
        n_checks++; if (bus_if.grant !== 2'b01) begin n_fail++; $display("FAIL a0_grant got=%b exp=01", bus_if.grant); end
        tick();
        bus_if.req_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            n_checks++; if (bus_if.ser_bit !== w[8-k] || bus_if.busy !== 1'b1 || bus_if.done !== 1'b0)
                begin n_fail++; $display("FAIL a0_shift%0d ser=%b busy=%b done=%b exp ser=%b busy=1 done=0", k, bus_if.ser_bit, bus_if.busy, bus_if.done, w[8-k]); end
            tick();
        end
        #1;
        n_checks++; if (bus_if.done !== 1'b1) begin n_fail++; $display("FAIL a0_done got=%b exp=1", bus_if.done); end
        n_checks++; if (bus_if.done_id !== 1'b0) begin n_fail++; $display("FAIL a0_done_id got=%b exp=0", bus_if.done_id); end
        n_checks++; if (bus_if.match_count !== 3'd7) begin n_fail++; $display("FAIL a0_count got=%0d exp=7", bus_if.match_count); end
        n_checks++; if (bus_if.ser_bit !== 1'b0 || bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL a0_report ser=%b busy=%b exp 0/1", bus_if.ser_bit, bus_if.busy); end
        tick();
        #1;
        n_checks++; if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.match_count !== 3'd7)
            begin n_fail++; $display("FAIL a0_after done=%b busy=%b cnt=%0d exp 0/0/7", bus_if.done, bus_if.busy, bus_if.match_count); end
    endtask

    task automatic test_single_b_alt();
        logic [7:0] w;
        w = 8'h55;
        bus_if.req_b = 1'b1; bus_if.word_b = w;
        #1;
        n_checks++; if (bus_if.grant !== 2'b10) begin n_fail++; $display("FAIL b55_grant got=%b exp=10", bus_if.grant); end
        tick();
        bus_if.req_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            n_checks++; if (bus_if.ser_bit !== w[8-k]) begin n_fail++; $display("FAIL b55_ser%0d got=%b exp=%b", k, bus_if.ser_bit, w[8-k]); end
            tick();
        end
        #1;
        n_checks++; if (bus_if.done !== 1'b1 || bus_if.done_id !== 1'b1 || bus_if.match_count !== 3'd0)
            begin n_fail++; $display("FAIL b55_report done=%b id=%b cnt=%0d exp 1/1/0", bus_if.done, bus_if.done_id, bus_if.match_count); end
        tick();
    endtask

    task automatic test_ignore_during_job();
        bus_if.req_b = 1'b1; bus_if.word_b = 8'h3C;
        #1;
        n_checks++; if (bus_if.grant !== 2'b10) begin n_fail++; $display("FAIL ign_grant got=%b exp=10", bus_if.grant); end
        tick();
        bus_if.req_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            bus_if.req_a = (k >= 3 && k <= 5);
            bus_if.word_a = 8'h00;
            #1;
            n_checks++; if (bus_if.grant !== 2'b00 || bus_if.busy !== 1'b1)
                begin n_fail++; $display("FAIL ign_shift%0d grant=%b busy=%b exp 00/1", k, bus_if.grant, bus_if.busy); end
            tick();
        end
        #1;
        n_checks++; if (bus_if.done !== 1'b1 || bus_if.done_id !== 1'b1 || bus_if.match_count !== 3'd2)
            begin n_fail++; $display("FAIL ign_report done=%b id=%b cnt=%0d exp 1/1/2", bus_if.done, bus_if.done_id, bus_if.match_count); end
        tick();
        #1;
        n_checks++; if (bus_if.grant !== 2'b00 || bus_if.busy !== 1'b0)
            begin n_fail++; $display("FAIL ign_not_queued grant=%b busy=%b exp 00/0", bus_if.grant, bus_if.busy); end
        tick();
    endtask

    task automatic test_contention();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        bus_if.req_a = 1'b1; bus_if.word_a = 8'hF0;
        bus_if.req_b = 1'b1; bus_if.word_b = 8'h81;
        #1;
        n_checks++; if (bus_if.grant !== 2'b01) begin n_fail++; $display("FAIL rr_first got=%b exp=01", bus_if.grant); end
        for (int c = 1; c <= 9; c++) begin
            tick();
            #1;
            n_checks++; if (bus_if.grant !== 2'b00) begin n_fail++; $display("FAIL rr_hold%0d grant=%b exp=00", c, bus_if.grant); end
        end
        n_checks++; if (bus_if.done !== 1'b1 || bus_if.done_id !== 1'b0 || bus_if.match_count !== 3'd3)
            begin n_fail++; $display("FAIL rr_a_report done=%b id=%b cnt=%0d exp 1/0/3", bus_if.done, bus_if.done_id, bus_if.match_count); end
        tick();
        #1;
        n_checks++; if (bus_if.grant !== 2'b10) begin n_fail++; $display("FAIL rr_second got=%b exp=10", bus_if.grant); end
        tick();
        bus_if.req_a = 1'b0; bus_if.req_b = 1'b0;
        for (int c = 2; c <= 9; c++) tick();
        #1;
        n_checks++; if (bus_if.done !== 1'b1 || bus_if.done_id !== 1'b1 || bus_if.match_count !== 3'd5)
            begin n_fail++; $display("FAIL rr_b_report done=%b id=%b cnt=%0d exp 1/1/5", bus_if.done, bus_if.done_id, bus_if.match_count); end
        tick();
    endtask

    task automatic test_reset_mid_job();
        bus_if.req_a = 1'b1; bus_if.word_a = 8'hFF;
        #1;
        n_checks++; if (bus_if.grant !== 2'b01) begin n_fail++; $display("FAIL rst_grant got=%b exp=01", bus_if.grant); end
        tick();
        bus_if.req_a = 1'b0;
        tick(); tick(); tick();
        #1;
        n_checks++; if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_before got=%b exp=1", bus_if.busy); end
        resetn = 1'b0;
        tick();
        #1;
        n_checks++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.ser_bit !== 1'b0 || bus_if.grant !== 2'b00)
            begin n_fail++; $display("FAIL rst_outputs busy=%b done=%b ser=%b grant=%b exp all 0", bus_if.busy, bus_if.done, bus_if.ser_bit, bus_if.grant); end
        n_checks++; if (bus_if.done_id !== 1'b0 || bus_if.match_count !== 3'd0)
            begin n_fail++; $display("FAIL rst_result id=%b cnt=%0d exp 0/0", bus_if.done_id, bus_if.match_count); end
        resetn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            #1;
            n_checks++; if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0)
                begin n_fail++; $display("FAIL rst_no_done%0d done=%b busy=%b exp 0/0", c, bus_if.done, bus_if.busy); end
        end
        bus_if.req_a = 1'b1; bus_if.word_a = 8'h00;
        #1;
        n_checks++; if (bus_if.grant !== 2'b01) begin n_fail++; $display("FAIL rst_regrant got=%b exp=01", bus_if.grant); end
        tick();
        bus_if.req_a = 1'b0;
        for (int c = 2; c <= 9; c++) tick();
        #1;
        n_checks++; if (bus_if.done !== 1'b1 || bus_if.match_count !== 3'd7)
            begin n_fail++; $display("FAIL rst_rerun done=%b cnt=%0d exp 1/7", bus_if.done, bus_if.match_count); end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        bus_if.req_a = 1'b0; bus_if.word_a = 8'h00;
        bus_if.req_b = 1'b0; bus_if.word_b = 8'h00;
        @(negedge clk);
        test_reset();
        test_single_a_zero();
        test_single_b_alt();
        test_ignore_during_job();
        test_contention();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/detector_arbiter.md
DETECTOR_ARBITER -- requirements
Module: detector_arbiter

Interface
REQ-001 Parameter WORD_W, default 8, number of serial bits per job.
REQ-002 Parameter CNT_W, default 3, width of match_count; SHALL hold WORD_W-1.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 resetn  input  1  reset, synchronous and active-low.
REQ-005 req_a  input  1  requester A job request, level, held until granted.
REQ-006 word_a  input  WORD_W  requester A data word, sampled on grant.
REQ-007 req_b  input  1  requester B job request, level, held until granted.
REQ-008 word_b  input  WORD_W  requester B data word, sampled on grant.
REQ-009 grant  output  2  one-hot grant pulse; bit0=A, bit1=B.
REQ-010 busy  output  1  high while a job is in SHIFT or REPORT.
REQ-011 ser_bit  output  1  bit presented to the shared detector this cycle.
REQ-012 done  output  1  one-cycle job-complete pulse.
REQ-013 done_id  output  1  owner of finished job (0=A, 1=B), valid with done.
REQ-014 match_count  output  CNT_W  "00" detections in finished job, valid from done until next done.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, REPORT; reset state IDLE.
REQ-016 IDLE with no request: outputs grant=00, busy=0, done=0.
REQ-017 IDLE with a request: grant SHALL pulse for that cycle, selected word loaded into shift register, detector cleared, next state SHIFT.
REQ-018 Arbitration SHALL be round-robin: if both request, grant the requester not granted last; first contention after reset grants A.
REQ-019 Single requester SHALL be granted regardless of round-robin pointer; pointer updates on every grant.
REQ-020 Requests during SHIFT/REPORT SHALL be ignored, not queued; grant stays 00.
REQ-021 SHIFT SHALL last exactly WORD_W cycles, ser_bit = word MSB first, one bit per cycle.
REQ-022 Shared detector (Moore, states Z0/Z1/Z2, Z2 output=1) SHALL count every bit position i≥1 where bit i and bit i-1 are both 0 (overlapping pairs).
REQ-023 After the last shift cycle the FSM SHALL enter REPORT for exactly one cycle: done=1, done_id, match_count updated; then IDLE.
REQ-024 Latency: grant at cycle T, first ser_bit at T+1, done at T+WORD_W+1; new grant no earlier than T+WORD_W+2.
REQ-025 match_count SHALL not wrap: max value WORD_W-1 (all-zero word).
REQ-026 Detector state SHALL not carry between jobs; first bit of each job starts from Z0.
REQ-027 ser_bit SHALL be 0 outside SHIFT.

Reset
REQ-028 resetn=0 at a rising edge SHALL force IDLE, grant=00, busy=0, done=0, done_id=0, match_count=0, ser_bit=0, RR pointer to A, detector to Z0.
REQ-029 Reset mid-job SHALL abort it with no done pulse; resetn takes priority over all other inputs.

Structure
REQ-030 Shared package SHALL hold state encoding (IDLE/SHIFT/REPORT), detector encoding (Z0/Z1/Z2), WORD_W/CNT_W defaults.
REQ-031 Detector SHALL be sub-module zero_pair_detector (clk, resetn, clear, in, out); arbiter counts cycles where out=1 during SHIFT.

Verification
REQ-032 req_a=1, word_a=8'h00 -> grant=01 at T, done at T+9, done_id=0, match_count=7.
REQ-033 req_b=1, word_b=8'h55 -> grant=10, ser_bit sequence 0,1,0,1,0,1,0,1, match_count=0.
REQ-034 req_a=req_b=1 held after reset, word_a=8'hF0, word_b=8'h81 -> A first (count 3), then B (count 5), grants 10 cycles apart.
REQ-035 req_a pulsed during B's SHIFT and dropped before REPORT -> no grant to A, busy unchanged, B completes normally.
REQ-036 resetn=0 at SHIFT cycle 4 of a job -> next cycle IDLE, all outputs 0, no done; subsequent job with 8'h00 still reports 7.
